// File: rtl/e203_ifu_pkg.sv
// Shared definitions for the IFU next-PC generator: controller states and
// instruction-length constants.
package e203_ifu_pkg;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_REQ,
    ST_RSP,
    ST_HOLD,
    ST_HALT
  } pcgen_state_e;

  localparam int unsigned RVC_LEN = 2;
  localparam int unsigned RVI_LEN = 4;

  function automatic int unsigned inst_len(input logic is_16bit);
    return is_16bit ? RVC_LEN : RVI_LEN;
  endfunction

endpackage

// File: rtl/e203_ifu_pcgen_if.sv
// Fetch-request channel between the next-PC generator (master) and the
// instruction fetch port (slave).
interface e203_ifu_pcgen_if #(
  parameter int PC_SIZE = 32
);

  logic               ifu_req_valid;
  logic               ifu_req_ready;
  logic [PC_SIZE-1:0] ifu_req_pc;
  logic               ifu_req_seq;

  modport master (
    output ifu_req_valid,
    output ifu_req_pc,
    output ifu_req_seq,
    input  ifu_req_ready
  );

  modport slave (
    input  ifu_req_valid,
    input  ifu_req_pc,
    input  ifu_req_seq,
    output ifu_req_ready
  );

endinterface

// File: rtl/e203_ifu_pcadd.sv
// PC_SIZE-bit address adder used for both the next-PC and the flush target.
module e203_ifu_pcadd #(
  parameter int PC_SIZE = 32
) (
  input  logic [PC_SIZE-1:0] op1,
  input  logic [PC_SIZE-1:0] op2,
  output logic [PC_SIZE-1:0] sum
);

  // Carry-out is dropped so addresses wrap modulo 2^PC_SIZE.
  assign sum = op1 + op2;

endmodule

// File: rtl/e203_ifu_pcgen.sv
// IFU next-PC generator and single-outstanding fetch-request issuer.
// Build option: define E203_IFU_PCGEN_HALT_EN to make halt_req/halt_ack functional.
module e203_ifu_pcgen
  import e203_ifu_pkg::*;
#(
  parameter int                 PC_SIZE   = 32,
  parameter logic [PC_SIZE-1:0] RESET_VEC = PC_SIZE'(32'h8000_0000)
) (
  input  logic               clk,
  input  logic               rst,

  input  logic               dec_valid,
  input  logic               dec_is_16bit,

  input  logic               prdt_taken,
  input  logic [PC_SIZE-1:0] prdt_pc_add_op1,
  input  logic [PC_SIZE-1:0] prdt_pc_add_op2,
  input  logic               bpu_wait,

  input  logic               pipe_flush_req,
  input  logic [PC_SIZE-1:0] pipe_flush_add_op1,
  input  logic [PC_SIZE-1:0] pipe_flush_add_op2,
  output logic               pipe_flush_ack,

  input  logic               halt_req,
  output logic               halt_ack,

  e203_ifu_pcgen_if.master   ifu,

  output logic [PC_SIZE-1:0] pc
);

  pcgen_state_e       state_r,      state_nxt;
  logic [PC_SIZE-1:0] req_pc_r,     req_pc_nxt;
  logic               req_seq_r,    req_seq_nxt;
  logic [PC_SIZE-1:0] pc_r,         pc_nxt;
  logic               drop_r,       drop_nxt;
  logic               flush_pend_r, flush_pend_nxt;
  logic [PC_SIZE-1:0] pend_pc_r,    pend_pc_nxt;

  logic [PC_SIZE-1:0] cur_pc;
  logic [PC_SIZE-1:0] add_op1;
  logic [PC_SIZE-1:0] add_op2;
  logic [PC_SIZE-1:0] nxt_pc;
  logic [PC_SIZE-1:0] flush_pc;
  logic               flush_ack;
  logic               halt_en_req;
  pcgen_state_e       eval_state;

`ifdef E203_IFU_PCGEN_HALT_EN
  assign halt_en_req = halt_req;
  assign halt_ack    = (state_r == ST_HALT);
`else
  logic unused_halt_req;
  assign unused_halt_req = halt_req;
  assign halt_en_req     = 1'b0;
  assign halt_ack        = 1'b0;
`endif

  // In RSP the instruction at decode is the one just fetched, so its PC is
  // still in req_pc_r; in HOLD it has already been captured in pc_r.
  assign cur_pc  = (state_r == ST_RSP) ? req_pc_r : pc_r;
  assign add_op1 = prdt_taken ? prdt_pc_add_op1 : cur_pc;
  assign add_op2 = prdt_taken ? prdt_pc_add_op2 : PC_SIZE'(inst_len(dec_is_16bit));

  e203_ifu_pcadd #(.PC_SIZE(PC_SIZE)) u_nxt_add (
    .op1 (add_op1),
    .op2 (add_op2),
    .sum (nxt_pc)
  );

  e203_ifu_pcadd #(.PC_SIZE(PC_SIZE)) u_flush_add (
    .op1 (pipe_flush_add_op1),
    .op2 (pipe_flush_add_op2),
    .sum (flush_pc)
  );

  assign flush_ack  = pipe_flush_req & (state_r != ST_BOOT);
  assign eval_state = bpu_wait    ? ST_HOLD :
                      halt_en_req ? ST_HALT : ST_REQ;

  always_comb begin
    // NOTE: every target gets its hold value before the case, so no branch
    // can leave one unassigned and infer a latch.
    state_nxt      = state_r;
    req_pc_nxt     = req_pc_r;
    req_seq_nxt    = req_seq_r;
    pc_nxt         = pc_r;
    drop_nxt       = drop_r;
    flush_pend_nxt = flush_pend_r;
    pend_pc_nxt    = pend_pc_r;

    case (state_r)
      ST_BOOT: state_nxt = ST_REQ;

      ST_REQ: begin
        // The request already offered must still complete; its response is
        // discarded later and the flush target is issued after it.
        if (flush_ack) begin
          drop_nxt       = 1'b1;
          flush_pend_nxt = 1'b1;
          pend_pc_nxt    = flush_pc;
        end
        if (ifu.ifu_req_ready) begin
          state_nxt = ST_RSP;
        end
      end

      ST_RSP: begin
        if (flush_ack) begin
          if (dec_valid) begin
            state_nxt      = ST_REQ;
            req_pc_nxt     = flush_pc;
            req_seq_nxt    = 1'b0;
            drop_nxt       = 1'b0;
            flush_pend_nxt = 1'b0;
          end else begin
            drop_nxt       = 1'b1;
            flush_pend_nxt = 1'b1;
            pend_pc_nxt    = flush_pc;
          end
        end else if (dec_valid) begin
          if (drop_r) begin
            state_nxt      = ST_REQ;
            drop_nxt       = 1'b0;
            flush_pend_nxt = 1'b0;
            if (flush_pend_r) begin
              req_pc_nxt  = pend_pc_r;
              req_seq_nxt = 1'b0;
            end
          end else begin
            pc_nxt    = req_pc_r;
            state_nxt = eval_state;
            if (!bpu_wait) begin
              req_pc_nxt  = nxt_pc;
              req_seq_nxt = ~prdt_taken;
            end
          end
        end
      end

      ST_HOLD: begin
        if (flush_ack) begin
          state_nxt   = ST_REQ;
          req_pc_nxt  = flush_pc;
          req_seq_nxt = 1'b0;
        end else begin
          state_nxt = eval_state;
          if (!bpu_wait) begin
            req_pc_nxt  = nxt_pc;
            req_seq_nxt = ~prdt_taken;
          end
        end
      end

      ST_HALT: begin
        // req_pc_r doubles as the resume PC while halted.
        if (flush_ack) begin
          req_pc_nxt  = flush_pc;
          req_seq_nxt = 1'b0;
        end
        if (!halt_en_req) begin
          state_nxt = ST_REQ;
        end
      end

      default: state_nxt = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every register sample the values
    // from before this edge, independent of statement order.
    if (rst) begin
      state_r      <= ST_BOOT;
      req_pc_r     <= RESET_VEC;
      req_seq_r    <= 1'b0;
      pc_r         <= RESET_VEC;
      drop_r       <= 1'b0;
      flush_pend_r <= 1'b0;
      pend_pc_r    <= RESET_VEC;
    end else begin
      state_r      <= state_nxt;
      req_pc_r     <= req_pc_nxt;
      req_seq_r    <= req_seq_nxt;
      pc_r         <= pc_nxt;
      drop_r       <= drop_nxt;
      flush_pend_r <= flush_pend_nxt;
      pend_pc_r    <= pend_pc_nxt;
    end
  end

  assign ifu.ifu_req_valid = (state_r == ST_REQ);
  assign ifu.ifu_req_pc    = req_pc_r;
  assign ifu.ifu_req_seq   = req_seq_r;
  assign pc                = pc_r;
  assign pipe_flush_ack    = flush_ack;

endmodule

// File: tb/tb_e203_ifu_pcgen.sv
// Self-checking bench for e203_ifu_pcgen: directed test-plan sequence with
// literal expectations, then randomized traffic against a transaction-level model.
module tb_e203_ifu_pcgen;

  localparam logic [31:0] RV = 32'h8000_0000;
`ifdef E203_IFU_PCGEN_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_valid, dec_is_16bit;
  logic        prdt_taken;
  logic [31:0] prdt_pc_add_op1, prdt_pc_add_op2;
  logic        bpu_wait;
  logic        pipe_flush_req;
  logic [31:0] pipe_flush_add_op1, pipe_flush_add_op2;
  logic        pipe_flush_ack;
  logic        halt_req, halt_ack;
  logic [31:0] pc;

  e203_ifu_pcgen_if #(.PC_SIZE(32)) ifu ();

  e203_ifu_pcgen #(.PC_SIZE(32), .RESET_VEC(RV)) dut (
    .clk                (clk),
    .rst                (rst),
    .dec_valid          (dec_valid),
    .dec_is_16bit       (dec_is_16bit),
    .prdt_taken         (prdt_taken),
    .prdt_pc_add_op1    (prdt_pc_add_op1),
    .prdt_pc_add_op2    (prdt_pc_add_op2),
    .bpu_wait           (bpu_wait),
    .pipe_flush_req     (pipe_flush_req),
    .pipe_flush_add_op1 (pipe_flush_add_op1),
    .pipe_flush_add_op2 (pipe_flush_add_op2),
    .pipe_flush_ack     (pipe_flush_ack),
    .halt_req           (halt_req),
    .halt_ack           (halt_ack),
    .ifu                (ifu),
    .pc                 (pc)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Transaction-level view of the fetch stream.
  bit          m_init    = 1'b0;
  bit          m_booting = 1'b0;   // reset just released, nothing offered yet
  bit          m_req_out = 1'b0;   // a fetch request is being offered
  bit          m_await   = 1'b0;   // request accepted, response outstanding
  bit          m_stall   = 1'b0;   // instruction at decode waits on the BPU
  bit          m_halt    = 1'b0;   // fetching stopped on halt
  bit          m_drop    = 1'b0;   // a flush target waits behind a stale response
  logic [31:0] m_drop_pc = '0;
  logic [31:0] m_req_pc  = '0;
  bit          m_seq     = 1'b0;
  logic [31:0] m_pc      = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic compare_model();
    check("model_valid",     32'(ifu.ifu_req_valid), 32'(m_req_out));
    check("model_req_pc",    ifu.ifu_req_pc,          m_req_pc);
    check("model_req_seq",   32'(ifu.ifu_req_seq),   32'(m_seq));
    check("model_pc",        pc,                      m_pc);
    check("model_flush_ack", 32'(pipe_flush_ack),    32'(pipe_flush_req && !m_booting));
    check("model_halt_ack",  32'(halt_ack),          32'(m_halt));
  endtask

  task automatic issue(input logic [31:0] addr, input bit seq);
    m_req_pc  = addr;
    m_seq     = seq;
    m_req_out = 1'b1;
  endtask

  // Instruction at decode at address cur is resolved (or keeps stalling).
  task automatic decide(input logic [31:0] cur);
    m_stall = bpu_wait;
    if (!bpu_wait) begin
      m_req_pc = prdt_taken ? prdt_pc_add_op1 + prdt_pc_add_op2
                            : cur + (dec_is_16bit ? 32'd2 : 32'd4);
      m_seq    = !prdt_taken;
      if (HALT_EN && halt_req) m_halt = 1'b1;
      else                     m_req_out = 1'b1;
    end
  endtask

  task automatic model_update();
    logic [31:0] tgt;
    bit          ack;
    if (rst) begin
      m_init = 1'b1; m_booting = 1'b1; m_req_out = 1'b0; m_await = 1'b0;
      m_stall = 1'b0; m_halt = 1'b0; m_drop = 1'b0;
      m_req_pc = RV; m_pc = RV; m_seq = 1'b0;
      return;
    end
    if (!m_init) return;
    tgt = pipe_flush_add_op1 + pipe_flush_add_op2;
    ack = pipe_flush_req && !m_booting;
    if (m_booting) begin
      m_booting = 1'b0;
      m_req_out = 1'b1;
    end else if (m_req_out) begin
      if (ack) begin m_drop = 1'b1; m_drop_pc = tgt; end
      if (ifu.ifu_req_ready) begin m_req_out = 1'b0; m_await = 1'b1; end
    end else if (m_await) begin
      if (ack && dec_valid) begin
        m_await = 1'b0; m_drop = 1'b0; issue(tgt, 1'b0);
      end else if (ack) begin
        m_drop = 1'b1; m_drop_pc = tgt;
      end else if (dec_valid) begin
        m_await = 1'b0;
        if (m_drop) begin
          m_drop = 1'b0; issue(m_drop_pc, 1'b0);
        end else begin
          m_pc = m_req_pc;
          decide(m_req_pc);
        end
      end
    end else if (m_stall) begin
      if (ack) begin m_stall = 1'b0; issue(tgt, 1'b0); end
      else decide(m_pc);
    end else if (m_halt) begin
      if (ack) begin m_req_pc = tgt; m_seq = 1'b0; end
      if (!(HALT_EN && halt_req)) begin m_halt = 1'b0; m_req_out = 1'b1; end
    end
  endtask

  // Inputs are set at the falling edge; outputs are compared just after it.
  task automatic step();
    #1;
    if (m_init) compare_model();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic handshake();
    ifu.ifu_req_ready = 1'b1;
    step();
    ifu.ifu_req_ready = 1'b0;
  endtask

  task automatic respond(input logic is16, input logic taken,
                         input logic [31:0] op1, input logic [31:0] op2);
    dec_valid = 1'b1; dec_is_16bit = is16; prdt_taken = taken;
    prdt_pc_add_op1 = op1; prdt_pc_add_op2 = op2;
    step();
    dec_valid = 1'b0; prdt_taken = 1'b0;
  endtask

  task automatic rand_inputs();
    ifu.ifu_req_ready = ($urandom_range(0, 2) != 0);
    if (m_stall) begin
      dec_valid = 1'b1;
      bpu_wait  = ($urandom_range(0, 2) == 0);
    end else if (m_await) begin
      dec_valid       = ($urandom_range(0, 1) == 1);
      bpu_wait        = dec_valid && ($urandom_range(0, 3) == 0);
      dec_is_16bit    = ($urandom_range(0, 1) == 1);
      prdt_taken      = ($urandom_range(0, 2) == 0);
      prdt_pc_add_op1 = $urandom;
      prdt_pc_add_op2 = $urandom;
    end else begin
      dec_valid = 1'b0;
      bpu_wait  = 1'b0;
    end
    pipe_flush_req     = ($urandom_range(0, 9) == 0);
    pipe_flush_add_op1 = $urandom;
    pipe_flush_add_op2 = $urandom;
    if (halt_req) halt_req = ($urandom_range(0, 5) != 0);
    else          halt_req = ($urandom_range(0, 29) == 0);
    rst = ($urandom_range(0, 499) == 0);
  endtask

  initial begin
    rst = 1'b1; dec_valid = 1'b0; dec_is_16bit = 1'b0; prdt_taken = 1'b0;
    prdt_pc_add_op1 = '0; prdt_pc_add_op2 = '0; bpu_wait = 1'b0;
    pipe_flush_req = 1'b1; pipe_flush_add_op1 = 32'h40; pipe_flush_add_op2 = 32'h4;
    halt_req = 1'b0; ifu.ifu_req_ready = 1'b0;

    // Reset state; a flush request during reset is not acknowledged.
    step(); step();
    check("rst_valid",   32'(ifu.ifu_req_valid), 32'd0);
    check("rst_req_pc",  ifu.ifu_req_pc,          RV);
    check("rst_seq",     32'(ifu.ifu_req_seq),   32'd0);
    check("rst_pc",      pc,                      RV);
    check("rst_ack",     32'(pipe_flush_ack),    32'd0);
    check("rst_halt",    32'(halt_ack),          32'd0);

    // First request in the second cycle after release.
    rst = 1'b0; pipe_flush_req = 1'b0; ifu.ifu_req_ready = 1'b1;
    #1 check("boot_valid", 32'(ifu.ifu_req_valid), 32'd0);
    step();
    check("first_valid", 32'(ifu.ifu_req_valid), 32'd1);
    check("first_pc",    ifu.ifu_req_pc,          RV);
    check("first_seq",   32'(ifu.ifu_req_seq),   32'd0);
    step();
    ifu.ifu_req_ready = 1'b0;

    // Sequential fetch: 32-bit then RVC.
    respond(1'b0, 1'b0, '0, '0);
    check("seq32_valid", 32'(ifu.ifu_req_valid), 32'd1);
    check("seq32_pc",    ifu.ifu_req_pc,          32'h8000_0004);
    check("seq32_seq",   32'(ifu.ifu_req_seq),   32'd1);
    check("seq32_decpc", pc,                      RV);
    handshake();
    respond(1'b1, 1'b0, '0, '0);
    check("rvc_pc",      ifu.ifu_req_pc,          32'h8000_0006);
    check("rvc_seq",     32'(ifu.ifu_req_seq),   32'd1);

    // Taken branch with wrapping operands.
    handshake();
    respond(1'b0, 1'b1, 32'h8000_0010, 32'hFFFF_FFF0);
    check("taken_pc",    ifu.ifu_req_pc,          32'h8000_0000);
    check("taken_seq",   32'(ifu.ifu_req_seq),   32'd0);
    check("taken_decpc", pc,                      32'h8000_0006);

    // BPU stall for three cycles.
    handshake();
    dec_valid = 1'b1; dec_is_16bit = 1'b0; bpu_wait = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_valid", 32'(ifu.ifu_req_valid), 32'd0);
    end
    bpu_wait = 1'b0;
    step();
    dec_valid = 1'b0;
    check("unstall_valid", 32'(ifu.ifu_req_valid), 32'd1);
    check("unstall_pc",    ifu.ifu_req_pc,          32'h8000_0004);

    // Flush while waiting for a response.
    handshake();
    pipe_flush_req = 1'b1; pipe_flush_add_op1 = 32'h100; pipe_flush_add_op2 = 32'h20;
    #1 check("rspflush_ack", 32'(pipe_flush_ack), 32'd1);
    step();
    pipe_flush_req = 1'b0;
    check("rspflush_idle", 32'(ifu.ifu_req_valid), 32'd0);
    respond(1'b0, 1'b1, 32'h1234, 32'h0);
    check("rspflush_valid", 32'(ifu.ifu_req_valid), 32'd1);
    check("rspflush_pc",    ifu.ifu_req_pc,          32'h120);
    check("rspflush_seq",   32'(ifu.ifu_req_seq),   32'd0);

    // Flush during a stall redirects in the next cycle; target wraps.
    handshake();
    dec_valid = 1'b1; bpu_wait = 1'b1;
    step();
    pipe_flush_req = 1'b1; pipe_flush_add_op1 = 32'hFFFF_FFFC; pipe_flush_add_op2 = 32'h8;
    step();
    pipe_flush_req = 1'b0; dec_valid = 1'b0; bpu_wait = 1'b0;
    check("holdflush_valid", 32'(ifu.ifu_req_valid), 32'd1);
    check("holdflush_pc",    ifu.ifu_req_pc,          32'h4);
    check("holdflush_decpc", pc,                      32'h120);

    // Flush while a request is still offered: request stays stable, its
    // response is dropped, then the target goes out.
    pipe_flush_req = 1'b1; pipe_flush_add_op1 = 32'h300; pipe_flush_add_op2 = 32'h4;
    step();
    pipe_flush_req = 1'b0;
    check("reqflush_stable", ifu.ifu_req_pc, 32'h4);
    handshake();
    respond(1'b0, 1'b0, '0, '0);
    check("reqflush_pc",  ifu.ifu_req_pc,        32'h304);
    check("reqflush_seq", 32'(ifu.ifu_req_seq), 32'd0);

    // Halt, flush while halted, then resume.
    handshake();
    halt_req = 1'b1;
    respond(1'b0, 1'b0, '0, '0);
    check("halt_ack",   32'(halt_ack),          32'(HALT_EN));
    check("halt_valid", 32'(ifu.ifu_req_valid), 32'(!HALT_EN));
    check("halt_next",  ifu.ifu_req_pc,          32'h308);
    step();
    pipe_flush_req = 1'b1; pipe_flush_add_op1 = 32'h1F0; pipe_flush_add_op2 = 32'h10;
    #1 check("haltflush_ack", 32'(pipe_flush_ack), 32'd1);
    step();
    pipe_flush_req = 1'b0; halt_req = 1'b0;
    step();
    check("resume_valid", 32'(ifu.ifu_req_valid), 32'd1);
    check("resume_pc",    ifu.ifu_req_pc,          HALT_EN ? 32'h200 : 32'h308);
    check("resume_hack",  32'(halt_ack),          32'd0);

    // Reset in the middle of an offered request discards all tracking.
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_valid", 32'(ifu.ifu_req_valid), 32'd0);
    check("midrst_pc",    ifu.ifu_req_pc,          RV);
    step();
    check("midrst_req",   32'(ifu.ifu_req_valid), 32'd1);
    handshake();
    respond(1'b0, 1'b0, '0, '0);
    check("midrst_next",  ifu.ifu_req_pc,          32'h8000_0004);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      rand_inputs();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
